cpc_bus_timer: RTL

Parametrised timebase and bus-timing sequencer for the CPC motherboard. It derives the 16 MHz and 4 MHz clock enables and the 1 MHz bus slot from the system clock, and generates the CPU WAIT line that aligns memory and I/O cycles to that slot. It adds a slot-aligned CPU turbo mode (8 MHz CPU enables with a 4 MHz video and peripheral timebase) and an optional wait-state statistics counter. It sits between the system clock and the CPU, CRTC, gate array and PSG enables.

---
 rtl/cpc_bus_timer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cpc_bus_timer.sv
// ----------------------------------------------------------------------------
// cpc_bus_timer
//
// Timebase and bus-timing sequencer for the CPC motherboard. Divides the
// system clock into 16 MHz and 4 MHz clock enables and a 1 MHz bus slot, and
// drives the CPU WAIT line so memory and I/O cycles line up with the slot
// window. A turbo mode runs the CPU enables at 8 MHz while the 4 MHz video and
// peripheral enables keep their normal cadence. Turbo changes are applied only
// at a slot boundary while the bus is idle.
//
// Optional feature macro: CPC_WAIT_STATS_EN
//   defined     -> wait_cnt counts inserted wait T-states, stat_clr clears it
//   not defined -> wait_cnt is tied to 0 and stat_clr is ignored
//
// Parameters:
//   CLK_DIV     clk cycles per ce_16 tick (>= 1)
//   SLOT_LEN    4 MHz ticks per bus slot (power of two, 2..16)
//   SLOT_PHASE  slot index during which cyc1MHz is high (0..SLOT_LEN-1)
//   CNT_W       width of wait_cnt
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   turbo      in   requested CPU speed (0 = 4 MHz, 1 = 8 MHz)
//   no_wait    in   forces wait_n high
//   mreq_n     in   CPU MREQ, active low
//   iorq_n     in   CPU IORQ, active low
//   stat_clr   in   clears wait_cnt
//   ce_16      out  16 MHz enable
//   ce_4p      out  4 MHz enable, rising phase
//   ce_4n      out  4 MHz enable, falling phase
//   cyc1MHz    out  bus-slot window
//   cpu_cen_p  out  CPU positive-phase enable
//   cpu_cen_n  out  CPU negative-phase enable
//   wait_n     out  CPU WAIT, active low
//   turbo_act  out  turbo mode currently applied
//   wait_cnt   out  count of inserted wait T-states (saturating)
// ----------------------------------------------------------------------------
module cpc_bus_timer #(
    parameter int CLK_DIV    = 2,
    parameter int SLOT_LEN   = 4,
    parameter int SLOT_PHASE = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             turbo,
    input  logic             no_wait,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             stat_clr,
    output logic             ce_16,
    output logic             ce_4p,
    output logic             ce_4n,
    output logic             cyc1MHz,
    output logic             cpu_cen_p,
    output logic             cpu_cen_n,
    output logic             wait_n,
    output logic             turbo_act,
    output logic [CNT_W-1:0] wait_cnt
);

    // A one-bit divider counter is kept even for CLK_DIV=1; it simply stays 0.
    localparam int D_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int S_W = $clog2(SLOT_LEN);

    localparam logic [D_W-1:0] D_LAST = D_W'(CLK_DIV - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SLOT_LEN - 1);
    localparam logic [S_W-1:0] S_WIN  = S_W'(SLOT_PHASE);

    logic [D_W-1:0] d;
    logic [1:0]     q;
    logic [S_W-1:0] s;

    logic d_wrap;
    logic q_wrap;
    logic slot_wrap;
    logic bus_idle;

    assign d_wrap    = (d == D_LAST);
    assign q_wrap    = d_wrap & (q == 2'd3);
    assign slot_wrap = q_wrap & (s == S_LAST);
    assign bus_idle  = mreq_n & iorq_n;

    // ------------------------------------------------------------------------
    // Phase counters. q and s wrap naturally: q is 2 bits wide and SLOT_LEN is
    // a power of two, so only d needs an explicit wrap compare.
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            d <= '0;
            q <= '0;
            s <= '0;
        end else begin
            d <= d_wrap ? '0 : d + 1'b1;
            if (d_wrap) begin
                q <= q + 2'd1;
            end
            if (q_wrap) begin
                s <= s + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Turbo mode is only switched on the last clk of a slot with the bus idle,
    // so the CPU never sees its enable cadence change inside a bus slot. A
    // request made while the bus is busy just waits for a later slot wrap.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_act <= 1'b0;
        end else if (slot_wrap && bus_idle) begin
            turbo_act <= turbo;
        end
    end

    // ------------------------------------------------------------------------
    // Enable decodes
    // ------------------------------------------------------------------------
    assign ce_16   = (d == '0);
    assign ce_4p   = ce_16 & (q == 2'd0);
    assign ce_4n   = ce_16 & (q == 2'd2);
    assign cyc1MHz = (s == S_WIN);

    // NOTE: outputs get a default before any conditional assignment so no
    // path through the block leaves them unassigned and infers a latch.
    always_comb begin
        cpu_cen_p = ce_4p;
        cpu_cen_n = ce_4n;
        if (turbo_act) begin
            // 8 MHz: alternate p/n on every 16 MHz tick, p on even q.
            cpu_cen_p = ce_16 & ~q[0];
            cpu_cen_n = ce_16 &  q[0];
        end
    end

    // Hold the CPU in wait while it has a memory or I/O request outside the
    // slot window; no_wait overrides the alignment in both speed modes.
    assign wait_n = no_wait | bus_idle | cyc1MHz;

    // ------------------------------------------------------------------------
    // Wait-state statistics
    // ------------------------------------------------------------------------
`ifdef CPC_WAIT_STATS_EN
    // A wait T-state is a CPU positive-phase enable that lands while WAIT is
    // asserted. The count saturates rather than wrapping; clear beats count.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            wait_cnt <= '0;
        end else if (cpu_cen_p && !wait_n && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign wait_cnt        = '0;
`endif

endmodule
